// File: rtl/tl_rx_write_handler_ecrc_seq.sv
// Receive-side TLP sequencer: registers beats toward an ECRC checker, extracts the digest,
// and strobes compare / seed reload. Define TL_RX_ECRC_SEQ_ERR_EN to enable the o_seq_err pulse.
module tl_rx_write_handler_ecrc_seq #(
    parameter int DW               = 32,
    parameter int VALID_DATA_WIDTH = 3,
    parameter int DATA_WIDTH       = 8 * DW
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [DATA_WIDTH-1:0]       i_data,
    input  logic                        i_sop,
    input  logic                        i_eop,
    input  logic [VALID_DATA_WIDTH-1:0] i_eop_dw,
    input  logic                        i_td,
    output logic [DATA_WIDTH-1:0]       o_crc_data,
    output logic [VALID_DATA_WIDTH-1:0] o_crc_len,
    output logic                        o_crc_en,
    output logic                        o_hdr_blk,
    output logic                        o_done,
    output logic [DW-1:0]               o_rcv_ecrc,
    output logic                        o_n_clr,
    output logic                        o_seq_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BODY,
        S_DONE,
        S_CLR
    } state_t;

    state_t                        state_q, state_d;
    logic                          td_q, td_d;
    logic [DATA_WIDTH-1:0]         crc_data_q, crc_data_d;
    logic [VALID_DATA_WIDTH-1:0]   crc_len_q, crc_len_d;
    logic                          crc_en_q, crc_en_d;
    logic                          hdr_blk_q, hdr_blk_d;
    logic                          done_q, done_d;
    logic                          n_clr_q, n_clr_d;
    logic [DW-1:0]                 rcv_ecrc_q, rcv_ecrc_d;

    logic                          xfer;
    logic                          idle_drop;
    logic                          abort;
    logic                          accept;
    logic                          frame_err;
    logic                          beat_td;
    logic [DW-1:0]                 eop_dw_word;

    assign o_ready     = (state_q == S_IDLE) || (state_q == S_BODY);
    assign xfer        = i_valid && o_ready;
    // A beat without sop while no TLP is open has no context and is discarded.
    assign idle_drop   = xfer && (state_q == S_IDLE) && !i_sop;
    assign abort       = xfer && (state_q == S_BODY) && i_sop;
    assign accept      = xfer && !idle_drop;
    assign frame_err   = idle_drop || abort;
    assign beat_td     = i_sop ? i_td : td_q;
    assign eop_dw_word = i_data[(DATA_WIDTH - 1) - DW * int'(i_eop_dw) -: DW];

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        state_d = state_q;
        td_d    = td_q;
        done_d  = 1'b0;
        n_clr_d = 1'b1;
        unique case (state_q)
            S_IDLE, S_BODY: begin
                if (accept) begin
                    if (i_sop) begin
                        td_d = i_td;
                    end
                    state_d = i_eop ? S_DONE : S_BODY;
                    if (abort) begin
                        n_clr_d = 1'b0;
                    end
                end
            end
            S_DONE: begin
                done_d  = td_q;
                state_d = S_CLR;
            end
            S_CLR: begin
                n_clr_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        crc_data_d = crc_data_q;
        crc_len_d  = crc_len_q;
        hdr_blk_d  = hdr_blk_q;
        rcv_ecrc_d = rcv_ecrc_q;
        crc_en_d   = 1'b0;
        if (accept) begin
            crc_data_d = i_data;
            hdr_blk_d  = i_sop;
            if (beat_td) begin
                if (!i_eop) begin
                    crc_en_d  = 1'b1;
                    crc_len_d = '1;
                end else begin
                    // Digest DW is never folded; a digest-only beat folds nothing.
                    rcv_ecrc_d = eop_dw_word;
                    if (i_eop_dw != '0) begin
                        crc_en_d  = 1'b1;
                        crc_len_d = i_eop_dw - VALID_DATA_WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
        if (i_rst) begin
            state_q    <= S_IDLE;
            td_q       <= 1'b0;
            crc_data_q <= '0;
            crc_len_q  <= '0;
            crc_en_q   <= 1'b0;
            hdr_blk_q  <= 1'b0;
            done_q     <= 1'b0;
            n_clr_q    <= 1'b1;
            rcv_ecrc_q <= '0;
        end else begin
            state_q    <= state_d;
            td_q       <= td_d;
            crc_data_q <= crc_data_d;
            crc_len_q  <= crc_len_d;
            crc_en_q   <= crc_en_d;
            hdr_blk_q  <= hdr_blk_d;
            done_q     <= done_d;
            n_clr_q    <= n_clr_d;
            rcv_ecrc_q <= rcv_ecrc_d;
        end
    end

    assign o_crc_data = crc_data_q;
    assign o_crc_len  = crc_len_q;
    assign o_crc_en   = crc_en_q;
    assign o_hdr_blk  = hdr_blk_q;
    assign o_done     = done_q;
    assign o_n_clr    = n_clr_q;
    assign o_rcv_ecrc = rcv_ecrc_q;

`ifdef TL_RX_ECRC_SEQ_ERR_EN
    logic seq_err_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= frame_err;
        end
    end

    assign o_seq_err = seq_err_q;
`else
    logic unused_frame_err;

    assign unused_frame_err = frame_err;
    assign o_seq_err        = 1'b0;
`endif

endmodule

// File: tb/tb_tl_rx_write_handler_ecrc_seq.sv
// Self-checking bench for tl_rx_write_handler_ecrc_seq: per-cycle model compare plus
// hand-computed expectations for each directed TLP scenario.
module tb_tl_rx_write_handler_ecrc_seq;

    localparam int DW   = 32;
    localparam int VW   = 3;
    localparam int DWD  = 8 * DW;
    localparam int MAXC = 4096;
`ifdef TL_RX_ECRC_SEQ_ERR_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic            i_clk;
    logic            i_rst;
    logic            i_valid;
    logic            o_ready;
    logic [DWD-1:0]  i_data;
    logic            i_sop;
    logic            i_eop;
    logic [VW-1:0]   i_eop_dw;
    logic            i_td;
    logic [DWD-1:0]  o_crc_data;
    logic [VW-1:0]   o_crc_len;
    logic            o_crc_en;
    logic            o_hdr_blk;
    logic            o_done;
    logic [DW-1:0]   o_rcv_ecrc;
    logic            o_n_clr;
    logic            o_seq_err;

    tl_rx_write_handler_ecrc_seq #(
        .DW              (DW),
        .VALID_DATA_WIDTH(VW),
        .DATA_WIDTH      (DWD)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .i_sop     (i_sop),
        .i_eop     (i_eop),
        .i_eop_dw  (i_eop_dw),
        .i_td      (i_td),
        .o_crc_data(o_crc_data),
        .o_crc_len (o_crc_len),
        .o_crc_en  (o_crc_en),
        .o_hdr_blk (o_hdr_blk),
        .o_done    (o_done),
        .o_rcv_ecrc(o_rcv_ecrc),
        .o_n_clr   (o_n_clr),
        .o_seq_err (o_seq_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [DWD-1:0] act, input logic [DWD-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Digest DW k of a beat, DW0 being the most significant word.
    function automatic logic [DW-1:0] dw_of(input logic [DWD-1:0] d, input logic [VW-1:0] k);
        logic [DWD-1:0] s;
        s = d << (DW * k);
        return s[DWD-1 -: DW];
    endfunction

    // Model: rules of the block expressed as scheduled future events per cycle.
    bit             m_open, m_td, m_take;
    logic [DWD-1:0] m_data;
    logic [VW-1:0]  m_len;
    logic           m_hdr;
    logic [DW-1:0]  m_rcv;
    bit             e_en[MAXC];
    bit             e_done[MAXC];
    bit             e_nclr_low[MAXC];
    bit             e_seq[MAXC];
    bit             e_blk[MAXC];

    always @(posedge i_clk) begin
        if (cyc + 4 < MAXC) begin
            if (i_rst) begin
                m_open = 1'b0; m_td = 1'b0;
                m_data = '0; m_len = '0; m_hdr = 1'b0; m_rcv = '0;
                for (int j = cyc + 1; j < cyc + 5; j++) begin
                    e_en[j] = 1'b0; e_done[j] = 1'b0; e_nclr_low[j] = 1'b0;
                    e_seq[j] = 1'b0; e_blk[j] = 1'b0;
                end
            end else if (i_valid && !e_blk[cyc]) begin
                m_take = 1'b1;
                if (i_sop) begin
                    if (m_open) begin
                        e_nclr_low[cyc + 1] = 1'b1;
                        e_seq[cyc + 1]      = SEQ_EN;
                    end
                    m_open = 1'b1;
                    m_td   = i_td;
                end else if (!m_open) begin
                    m_take         = 1'b0;
                    e_seq[cyc + 1] = SEQ_EN;
                end
                if (m_take) begin
                    m_data = i_data;
                    m_hdr  = i_sop;
                    if (!i_eop) begin
                        if (m_td) begin
                            e_en[cyc + 1] = 1'b1;
                            m_len         = 3'd7;
                        end
                    end else begin
                        m_open             = 1'b0;
                        e_blk[cyc + 1]     = 1'b1;
                        e_blk[cyc + 2]     = 1'b1;
                        e_done[cyc + 2]    = m_td;
                        e_nclr_low[cyc + 3] = 1'b1;
                        if (m_td) begin
                            m_rcv = dw_of(i_data, i_eop_dw);
                            if (i_eop_dw != 3'd0) begin
                                e_en[cyc + 1] = 1'b1;
                                m_len         = 3'(i_eop_dw - 3'd1);
                            end
                        end
                    end
                end
            end
        end
        cyc = cyc + 1;
    end

    // Observation logs used by the hand-computed scenario expectations.
    logic [VW-1:0] q_len[$];
    int            done_cnt, nclr_cnt, seq_cnt, rdy_low, done_cyc, nclr_cyc;
    logic [DW-1:0] last_rcv;

    task automatic clear_logs();
        q_len.delete();
        done_cnt = 0; nclr_cnt = 0; seq_cnt = 0; rdy_low = 0;
        done_cyc = -1; nclr_cyc = -1; last_rcv = '0;
    endtask

    always @(negedge i_clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            check("ready",    o_ready,    !e_blk[cyc]);
            check("crc_en",   o_crc_en,   e_en[cyc]);
            check("done",     o_done,     e_done[cyc]);
            check("n_clr",    o_n_clr,    !e_nclr_low[cyc]);
            check("seq_err",  o_seq_err,  e_seq[cyc]);
            check("crc_data", o_crc_data, m_data);
            check("crc_len",  o_crc_len,  m_len);
            check("hdr_blk",  o_hdr_blk,  m_hdr);
            check("rcv_ecrc", o_rcv_ecrc, m_rcv);
            check("en_done_excl", o_crc_en & o_done, 1'b0);
            if (o_crc_en) q_len.push_back(o_crc_len);
            if (o_done) begin done_cnt++; done_cyc = cyc; last_rcv = o_rcv_ecrc; end
            if (!o_n_clr) begin nclr_cnt++; nclr_cyc = cyc; end
            if (o_seq_err) seq_cnt++;
            if (!o_ready) rdy_low++;
        end
    end

    task automatic drive_idle();
        i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_td = 1'b0;
        i_eop_dw = '0; i_data = '0;
    endtask

    task automatic send(input bit sop, input bit eop, input logic [VW-1:0] k,
                        input bit td, input logic [DWD-1:0] d);
        bit r;
        r = 1'b0;
        i_valid = 1'b1; i_sop = sop; i_eop = eop; i_eop_dw = k; i_td = td; i_data = d;
        for (int n = 0; n < 16 && !r; n++) begin
            @(negedge i_clk);
            r = o_ready;
            @(posedge i_clk);
            #1;
        end
        check("send_accept", r, 1'b1);
        drive_idle();
    endtask

    task automatic idle(input int n);
        drive_idle();
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int t_x, rel;

    initial begin
        drive_idle();
        i_rst = 1'b1;
        clear_logs();
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_n_clr",    o_n_clr,    1'b1);
        check("rst_ready",    o_ready,    1'b1);
        check("rst_crc_data", o_crc_data, '0);
        check("rst_rcv",      o_rcv_ecrc, '0);
        i_rst = 1'b0;
        idle(2);

        // 3-beat TLP with digest in DW3.
        clear_logs();
        send(1, 0, 3'd0, 1, {8{32'h11111111}});
        send(0, 0, 3'd0, 0, {8{32'h22222222}});
        send(0, 1, 3'd3, 0, {32'hA0, 32'hA1, 32'hA2, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0});
        idle(6);
        check("s1_len_cnt", q_len.size(), 3);
        check("s1_len0", q_len[0], 3'd7);
        check("s1_len1", q_len[1], 3'd7);
        check("s1_len2", q_len[2], 3'd2);
        check("s1_done_cnt", done_cnt, 1);
        check("s1_rcv", last_rcv, 32'hDEADBEEF);
        check("s1_nclr_after_done", nclr_cyc - done_cyc, 1);

        // 2-beat TLP, digest-only eop beat.
        clear_logs();
        send(1, 0, 3'd0, 1, {8{32'h33333333}});
        send(0, 1, 3'd0, 0, {32'h12345678, {7{32'hFFFFFFFF}}});
        idle(6);
        check("s2_len_cnt", q_len.size(), 1);
        check("s2_done_cnt", done_cnt, 1);
        check("s2_rcv", last_rcv, 32'h12345678);
        check("s2_rdy_low", rdy_low, 2);

        // Single beat sop+eop without digest.
        clear_logs();
        send(1, 1, 3'd4, 0, {8{32'h44444444}});
        t_x = cyc - 1;
        idle(6);
        check("s3_len_cnt", q_len.size(), 0);
        check("s3_done_cnt", done_cnt, 0);
        check("s3_nclr_cnt", nclr_cnt, 1);
        check("s3_nclr_cyc", nclr_cyc, t_x + 3);
        check("s3_rdy_low", rdy_low, 2);

        // sop injected into an open TLP; second TLP completes normally.
        clear_logs();
        send(1, 0, 3'd0, 1, {8{32'h55555555}});
        send(0, 0, 3'd0, 0, {8{32'h66666666}});
        send(1, 0, 3'd0, 1, {8{32'h77777777}});
        send(0, 1, 3'd7, 0, {{7{32'h88888888}}, 32'hCAFEF00D});
        idle(6);
        check("s4_seq_cnt", seq_cnt, SEQ_EN ? 1 : 0);
        check("s4_done_cnt", done_cnt, 1);
        check("s4_rcv", last_rcv, 32'hCAFEF00D);
        check("s4_len_cnt", q_len.size(), 4);
        check("s4_len3", q_len[3], 3'd6);
        check("s4_nclr_cnt", nclr_cnt, 2);

        // Orphan eop beat with no open TLP is dropped.
        clear_logs();
        send(0, 1, 3'd2, 1, {8{32'h99999999}});
        idle(5);
        check("s5_len_cnt", q_len.size(), 0);
        check("s5_done_cnt", done_cnt, 0);
        check("s5_seq_cnt", seq_cnt, SEQ_EN ? 1 : 0);
        check("s5_nclr_cnt", nclr_cnt, 0);

        // Reset during BODY, then an immediate new TLP.
        clear_logs();
        send(1, 0, 3'd0, 1, {8{32'hAAAAAAAA}});
        send(0, 0, 3'd0, 0, {8{32'hBBBBBBBB}});
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        check("s6_rst_en",    o_crc_en,   1'b0);
        check("s6_rst_done",  o_done,     1'b0);
        check("s6_rst_nclr",  o_n_clr,    1'b1);
        check("s6_rst_hdr",   o_hdr_blk,  1'b0);
        check("s6_rst_data",  o_crc_data, '0);
        check("s6_rst_rcv",   o_rcv_ecrc, '0);
        check("s6_rst_ready", o_ready,    1'b1);
        i_rst = 1'b0;
        rel = cyc;
        send(1, 1, 3'd1, 1, {32'h01010101, 32'h0BADF00D, {6{32'h0}}});
        check("s6_no_wait", cyc, rel + 1);
        idle(6);
        check("s6_done_cnt", done_cnt, 1);
        check("s6_rcv", last_rcv, 32'h0BADF00D);
        check("s6_len0", q_len[q_len.size() - 1], 3'd0);

        // Back-to-back single-beat TLPs, each stalls two cycles.
        clear_logs();
        send(1, 1, 3'd7, 1, {{7{32'hC0C0C0C0}}, 32'h00000001});
        send(1, 1, 3'd7, 1, {{7{32'hD0D0D0D0}}, 32'h00000002});
        idle(6);
        check("s7_done_cnt", done_cnt, 2);
        check("s7_rcv", last_rcv, 32'h00000002);
        check("s7_rdy_low", rdy_low, 4);
        check("s7_len0", q_len[0], 3'd6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
